// File: rtl/world_map_arbiter.sv
// Shares the world-map read port between the display fetch path (strict priority) and rojobot lookups.
// Display pixels appear RD_LAT+2 cycles after input; display is never stalled, bot waits for idle slots.
module world_map_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 2,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_valid,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_pixel_out,
  output logic              disp_video_on_out,
  input  logic              bot_req,
  input  logic [ADDR_W-1:0] bot_addr,
  output logic              bot_ack,
  output logic [DATA_W-1:0] bot_data,
  output logic              bot_starve,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_RD, B_ACK} bot_state_e;

  localparam int              WC_W     = $clog2(MAX_WAIT + 2);
  localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);
  localparam logic [1:0]      RD_LAST  = 2'(RD_LAT);

  bot_state_e        state_q, state_d;
  logic              last_vld_q, last_vld_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              bot_starve_q, bot_starve_d;
  logic              bot_ack_q, bot_ack_d;
  logic [DATA_W-1:0] bot_data_q, bot_data_d;
  logic [RD_LAT:0]   vld_sr_q, vld_sr_d;
  logic [RD_LAT:0]   fresh_sr_q, fresh_sr_d;
  logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              von_q, von_d;

  logic disp_need;
  logic bot_grant;

  always_comb begin
    disp_need = disp_valid && (!last_vld_q || (disp_addr != last_addr_q));
    bot_grant = (state_q == B_WAIT) && !disp_need;

    // Repeated pixels of the scaled display reuse the held code and free the port.
    last_vld_d  = last_vld_q;
    last_addr_d = last_addr_q;
    if (disp_need) begin
      last_vld_d  = 1'b1;
      last_addr_d = disp_addr;
    end else if (!disp_valid) begin
      last_vld_d  = 1'b0;
    end

    mem_en_d   = disp_need || bot_grant;
    mem_addr_d = mem_addr_q;
    if (disp_need)      mem_addr_d = disp_addr;
    else if (bot_grant) mem_addr_d = bot_addr;

    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    wait_cnt_d = '0;
    bot_ack_d  = 1'b0;
    bot_data_d = bot_data_q;
    case (state_q)
      B_IDLE: if (bot_req) state_d = B_WAIT;
      B_WAIT: begin
        if (bot_grant) begin
          state_d  = B_RD;
          rd_cnt_d = '0;
        end else begin
          wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 1'b1;
        end
      end
      B_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          bot_data_d = mem_rdata;
          bot_ack_d  = 1'b1;
          state_d    = B_ACK;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      B_ACK:   state_d = B_IDLE;
      default: state_d = B_IDLE;
    endcase
    bot_starve_d = bot_starve_q || (wait_cnt_q > WAIT_MAX);

    // Tags travel alongside the read so the tail stage lines up with mem_rdata.
    vld_sr_d   = {vld_sr_q[RD_LAT-1:0], disp_valid};
    fresh_sr_d = {fresh_sr_q[RD_LAT-1:0], disp_need};

    disp_hold_d = disp_hold_q;
    if (fresh_sr_q[RD_LAT]) disp_hold_d = mem_rdata;

    von_d = vld_sr_q[RD_LAT];
    if (!vld_sr_q[RD_LAT])       pix_d = '0;
    else if (fresh_sr_q[RD_LAT]) pix_d = mem_rdata;
    else                         pix_d = disp_hold_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= B_IDLE;
      last_vld_q   <= 1'b0;
      last_addr_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      rd_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      bot_starve_q <= 1'b0;
      bot_ack_q    <= 1'b0;
      bot_data_q   <= '0;
      vld_sr_q     <= '0;
      fresh_sr_q   <= '0;
      disp_hold_q  <= '0;
      pix_q        <= '0;
      von_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_vld_q   <= last_vld_d;
      last_addr_q  <= last_addr_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      bot_starve_q <= bot_starve_d;
      bot_ack_q    <= bot_ack_d;
      bot_data_q   <= bot_data_d;
      vld_sr_q     <= vld_sr_d;
      fresh_sr_q   <= fresh_sr_d;
      disp_hold_q  <= disp_hold_d;
      pix_q        <= pix_d;
      von_q        <= von_d;
    end
  end

  assign mem_en            = mem_en_q;
  assign mem_addr          = mem_addr_q;
  assign bot_ack           = bot_ack_q;
  assign bot_data          = bot_data_q;
  assign bot_starve        = bot_starve_q;
  assign disp_pixel_out    = pix_q;
  assign disp_video_on_out = von_q;

endmodule

// File: tb/tb_world_map_arbiter.sv
// Directed bench for world_map_arbiter with a one-cycle registered world-map memory model.
module tb_world_map_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_valid;
  logic [13:0] disp_addr;
  logic [1:0]  disp_pixel_out;
  logic        disp_video_on_out;
  logic        bot_req;
  logic [13:0] bot_addr;
  logic        bot_ack;
  logic [1:0]  bot_data;
  logic        bot_starve;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [1:0]  mem_rdata = 2'b00;

  logic [1:0]  mem [0:16383];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  world_map_arbiter #(.ADDR_W(14), .DATA_W(2), .RD_LAT(1), .MAX_WAIT(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .disp_valid        (disp_valid),
    .disp_addr         (disp_addr),
    .disp_pixel_out    (disp_pixel_out),
    .disp_video_on_out (disp_video_on_out),
    .bot_req           (bot_req),
    .bot_addr          (bot_addr),
    .bot_ack           (bot_ack),
    .bot_data          (bot_data),
    .bot_starve        (bot_starve),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({mem_en, mem_addr, disp_pixel_out, disp_video_on_out, bot_ack, bot_data, bot_starve});
  endfunction

  initial begin
    int exp_pix;
    for (int i = 0; i < 16384; i++) mem[i] = i[1:0];
    mem[14'h1234] = 2'd2;
    mem[14'h0100] = 2'd1;

    // Reset with inputs toggling.
    reset_n = 1'b0; disp_valid = 1'b1; disp_addr = 14'h2a5c; bot_req = 1'b1; bot_addr = 14'h0777;
    @(negedge clk);
    chk("rst_cyc0", all_out(), 32'd0);
    disp_valid = 1'b0; disp_addr = 14'h15a3; bot_req = 1'b1; bot_addr = 14'h3888;
    @(negedge clk);
    chk("rst_cyc1", all_out(), 32'd0);
    reset_n = 1'b1; disp_valid = 1'b0; disp_addr = '0; bot_req = 1'b0; bot_addr = '0;
    @(negedge clk);
    chk("post_rst0", all_out(), 32'd0);
    @(negedge clk);
    chk("post_rst1", all_out(), 32'd0);

    // Display pixel repeated 6 cycles: single fetch, 6 output pixels.
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t2_mem_en", 32'(mem_en), 32'(k == 1));
        if (k == 1) chk("t2_mem_addr", 32'(mem_addr), 32'h0005);
        chk("t2_von", 32'(disp_video_on_out), 32'(k >= 3 && k <= 8));
        chk("t2_pix", 32'(disp_pixel_out), (k >= 3 && k <= 8) ? 32'd1 : 32'd0);
      end
      disp_valid = (k < 6);
      disp_addr  = 14'h0005;
    end

    // Bot read during blanking; request held through ack.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t3_mem_en", 32'(mem_en), 32'(k == 2));
        if (k == 2) chk("t3_mem_addr", 32'(mem_addr), 32'h1234);
        chk("t3_ack", 32'(bot_ack), 32'(k == 4));
        if (k >= 4) chk("t3_data", 32'(bot_data), 32'd2);
        chk("t3_von", 32'(disp_video_on_out), 32'd0);
      end
      disp_valid = 1'b0;
      bot_req    = (k <= 4);
      bot_addr   = 14'h1234;
    end

    // Display busy every cycle starves the bot; two repeat pixels let it in.
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("t4_mem_en", 32'(mem_en), 32'(k <= 21));
        if (k <= 20) chk("t4_mem_addr", 32'(mem_addr), 32'h0200 + 32'(k - 1));
        if (k == 21) chk("t4_bot_addr", 32'(mem_addr), 32'h0331);
      end
      if (k >= 3 && k <= 22)      exp_pix = (k - 3) % 4;
      else if (k == 23 || k == 24) exp_pix = 3;
      else                         exp_pix = 0;
      chk("t4_pix", 32'(disp_pixel_out), 32'(exp_pix));
      chk("t4_von", 32'(disp_video_on_out), 32'(k >= 3 && k <= 24));
      chk("t4_ack", 32'(bot_ack), 32'(k == 23));
      if (k >= 23) chk("t4_data", 32'(bot_data), 32'd1);
      if (k == 17) chk("t4_starve_early", 32'(bot_starve), 32'd0);
      if (k >= 19) chk("t4_starve", 32'(bot_starve), 32'd1);
      disp_valid = (k <= 21);
      disp_addr  = (k <= 19) ? 14'h0200 + 14'(k) : 14'h0213;
      bot_req    = (k < 23);
      bot_addr   = 14'h0331;
    end

    // Reset one cycle after a bot grant abandons the read.
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("t5_grant_en", 32'(mem_en), 32'd1);
        chk("t5_grant_addr", 32'(mem_addr), 32'h0002);
      end
      if (k >= 3) begin
        chk("t5_ack", 32'(bot_ack), 32'(k == 9));
        chk("t5_starve", 32'(bot_starve), 32'd0);
      end
      if (k == 3) chk("t5_data_clr", 32'(bot_data), 32'd0);
      if (k >= 3 && k <= 8) chk("t5_mem_en", 32'(mem_en), 32'(k == 7));
      if (k == 9) chk("t5_data", 32'(bot_data), 32'd2);
      reset_n    = (k != 2);
      disp_valid = 1'b0;
      bot_req    = (k <= 1) || (k >= 5 && k <= 9);
      bot_addr   = 14'h0002;
    end

    // Line end, blanking, refetch of the same address with changed memory.
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("t6_mem_en", 32'(mem_en), 32'(k == 1 || k == 7));
        if (k == 1 || k == 7) chk("t6_mem_addr", 32'(mem_addr), 32'h0100);
      end
      if (k == 3 || k == 4)            exp_pix = 1;
      else if (k >= 9 && k <= 11)      exp_pix = 3;
      else                              exp_pix = 0;
      chk("t6_pix", 32'(disp_pixel_out), 32'(exp_pix));
      chk("t6_von", 32'(disp_video_on_out), 32'((k >= 3 && k <= 4) || (k >= 9 && k <= 11)));
      if (k == 3) mem[14'h0100] = 2'd3;
      disp_valid = (k <= 1) || (k >= 6 && k <= 8);
      disp_addr  = 14'h0100;
      bot_req    = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
